// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative leading/trailing-one normalizer.
// Accepts an operand, shifts it one bit per cycle until the selected end bit
// is set, then presents the normalized word and the number of shifts applied.
// Left mode (dir=0) finds the leading one; right mode (dir=1) finds the
// trailing one. An all-zero operand is flagged with zero=1.
module shift_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] shamt,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] shamt_q, shamt_d;
  logic             zero_q, zero_d;

  // The bit that terminates the scan: MSB when normalizing left, LSB when right.
  logic end_hit;
  assign end_hit = dir_q ? work_q[0] : work_q[WIDTH-1];

  // Next-state and datapath decisions for the IDLE/SCAN/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = d;
          dir_d   = dir;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (work_q == '0) begin
          zero_d  = 1'b1;
          res_d   = '0;
          shamt_d = '0;
          state_d = DONE;
        end else if (end_hit) begin
          res_d   = work_q;
          shamt_d = cnt_q;
          state_d = DONE;
        end else begin
          work_d = dir_q ? (work_q >> 1) : (work_q << 1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
    end
  end

  // Scan working registers.
  always_ff @(posedge clk) begin
    // NOTE: these are left out of reset on purpose; they are always loaded on
    // accept before being read, so a reset would only add fan-out.
    work_q <= work_d;
    dir_q  <= dir_d;
    cnt_q  <= cnt_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign q         = res_q;
  assign shamt     = shamt_q;
  assign zero      = zero_q;

  // A nonzero operand must reach its end bit within WIDTH-1 shifts.
  cnt_no_wrap: assert property (@(posedge clk) disable iff (rst)
    !(state_q == SCAN && work_q != '0 && !end_hit && cnt_q == CNT_W'(WIDTH - 1)));

endmodule
